seq_divider: RTL and testbench
==============================

# seq_divider

Iterative radix-2 integer divider for the ALU's M-extension datapath. It performs DIV/DIVU/REM/REMU as the sequential counterpart to the single-cycle signed multiplier, and returns quotient and remainder together. Operands enter through a valid/ready handshake. Results are held under a valid/ready handshake until consumed. Divide-by-zero and signed overflow follow RISC-V semantics, with an optional trap path feeding the exceptions stage.

## Interface
- WIDTH, 32, operand/result width; iteration count equals WIDTH
- clk  input  1  rising-edge clock; single clock domain
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  divider idle, can accept
- dividend  input  WIDTH  numerator a
- divisor  input  WIDTH  denominator b
- is_signed  input  1  1 = DIV/REM two's-complement, 0 = DIVU/REMU
- out_valid  output  1  result valid, held until out_ready
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  quotient
- remainder  output  WIDTH  remainder
- div_by_zero  output  1  flag, valid with out_valid
- overflow  output  1  signed overflow flag (MIN / -1), valid with out_valid
- trap  output  1  exception request, valid with out_valid (see Configuration)

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch the operands and is_signed.
  - If divisor==0 or (is_signed & dividend==MIN & divisor==all-ones), go to DONE with the special result.
  - Otherwise store magnitudes (absolute values when is_signed), record q_neg = sign(a)^sign(b) and r_neg = sign(a), clear partial remainder and count, and go to CALC.
- CALC:
  - One restoring step per cycle: shift {rem,quo} left 1 and bring in the next dividend MSB.
  - If rem >= |b|, subtract |b| and set quo LSB.
  - Partial remainder is WIDTH+1 bits, so there is no loss at |b| = 2^(WIDTH-1).
  - After WIDTH steps, go to FIXUP.
- FIXUP: negate quo if q_neg, negate rem if r_neg (signed only); go to DONE.
- DONE:
  - out_valid=1; outputs stable.
  - On out_ready, go to IDLE.
  - in_ready=0 in DONE, so there is no accept in the same cycle as result handoff.
- Special results:
  - Divide by zero: quotient = all-ones, remainder = dividend, div_by_zero=1.
  - Overflow: quotient = MIN (2^(WIDTH-1)), remainder = 0, overflow=1.
  - div_by_zero takes precedence; overflow cannot coexist.
- Unsigned mode never sets overflow.
- Results always satisfy dividend = quotient*divisor + remainder (mod 2^WIDTH), with |remainder| < |divisor| for nonzero divisor.

## Timing
- Reset values:
  - State IDLE.
  - in_ready=1, out_valid=0.
  - quotient, remainder = 0.
  - div_by_zero, overflow, trap = 0.
- rst mid-operation (CALC, FIXUP or DONE) aborts the operation: IDLE on the next edge, result discarded, no out_valid.
- Normal latency: the accepting edge is E0. CALC edges are E1..E32 (WIDTH=32), FIXUP is E33, and out_valid is high from E33 onward. That is 33 edges in general, WIDTH+1.
- Special-case latency: out_valid is high after E0 (1 edge). No CALC or FIXUP.
- Backpressure: out_valid, quotient, remainder and flags are held unchanged indefinitely while out_ready=0.
- Back-to-back throughput: one operation per WIDTH+3 cycles minimum (accept, WIDTH, fixup, handoff).
- Operand inputs are ignored outside IDLE, and may change freely after acceptance.

## Configuration
- SEQ_DIVIDER_TRAP_EN defined:
  - A divide-by-zero result asserts trap=1 with out_valid.
  - quotient and remainder are forced to the poison pattern {WIDTH/4{4'hB}} (32'hBBBB_BBBB).
  - div_by_zero is still set.
  - Overflow does not trap; it returns the RISC-V values.
- Not defined:
  - trap is tied to 0.
  - All special cases return RISC-V architectural values only.

## Test plan
- Unsigned 100 / 7, is_signed=0 -> quotient=14, remainder=2, flags 0, out_valid 33 edges after accept.
- Signed -7 / 2 (32'hFFFF_FFF9 / 2) -> quotient=32'hFFFF_FFFD (-3), remainder=32'hFFFF_FFFF (-1).
- Signed 32'h8000_0000 / 32'hFFFF_FFFF -> quotient=32'h8000_0000, remainder=0, overflow=1, out_valid after 1 edge.
- 1234 / 0 -> quotient=32'hFFFF_FFFF, remainder=1234, div_by_zero=1 with macro off. With SEQ_DIVIDER_TRAP_EN: trap=1, both results 32'hBBBB_BBBB.
- Unsigned 32'hFFFF_FFFF / 32'h8000_0000 with out_ready=0 for 10 cycles -> quotient=1, remainder=32'h7FFF_FFFF held stable. in_ready rises one edge after out_ready.
- Assert rst at CALC step 10, then launch 50 / 5 -> no stale out_valid. Result quotient=10, remainder=0, with normal latency.

Source files
------------

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider (DIV/DIVU/REM/REMU) with valid/ready handshakes on both sides.
// Optional macro SEQ_DIVIDER_TRAP_EN: divide-by-zero raises trap and returns a poison pattern.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow,
  output logic             trap
);

  // state | meaning
  // IDLE  | ready for operands
  // CALC  | one restoring step per cycle, WIDTH steps
  // FIXUP | apply result signs
  // DONE  | result held until out_ready
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic             a_neg, b_neg;
  logic             zero_case, ovf_case;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic             ge;

  assign a_neg     = is_signed & dividend[WIDTH-1];
  assign b_neg     = is_signed & divisor[WIDTH-1];
  assign a_mag     = a_neg ? -dividend : dividend;
  assign b_mag     = b_neg ? -divisor : divisor;
  assign zero_case = (divisor == '0);
  assign ovf_case  = is_signed && (dividend == MIN_V) && (divisor == '1);

  // Shifted partial remainder needs WIDTH+1 bits; the top bit of the difference is the borrow.
  assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
  assign rem_sub = rem_sh - {1'b0, bmag_q};
  assign ge      = ~rem_sub[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid) state_d = (zero_case || ovf_case) ? S_DONE : S_CALC;
      S_CALC:  if (cnt_q == '0) state_d = S_FIXUP;
      S_FIXUP: state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

`ifdef SEQ_DIVIDER_TRAP_EN
  localparam logic [WIDTH-1:0] POISON = {(WIDTH/4){4'hB}};
  logic trap_q, trap_d;
`endif

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    bmag_d = bmag_q;
    cnt_d  = cnt_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    quot_d = quot_q;
    remo_d = remo_q;
    dbz_d  = dbz_q;
    ovf_d  = ovf_q;
`ifdef SEQ_DIVIDER_TRAP_EN
    trap_d = trap_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          dbz_d = 1'b0;
          ovf_d = 1'b0;
`ifdef SEQ_DIVIDER_TRAP_EN
          trap_d = 1'b0;
`endif
          if (zero_case) begin
            dbz_d  = 1'b1;
`ifdef SEQ_DIVIDER_TRAP_EN
            trap_d = 1'b1;
            quot_d = POISON;
            remo_d = POISON;
`else
            quot_d = '1;
            remo_d = dividend;
`endif
          end else if (ovf_case) begin
            ovf_d  = 1'b1;
            quot_d = MIN_V;
            remo_d = '0;
          end else begin
            quo_d  = a_mag;
            rem_d  = '0;
            bmag_d = b_mag;
            cnt_d  = CW'(WIDTH - 1);
            qneg_d = a_neg ^ b_neg;
            rneg_d = a_neg;
          end
        end
      end
      S_CALC: begin
        rem_d = ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ge};
        cnt_d = cnt_q - 1'b1;
      end
      S_FIXUP: begin
        quot_d = qneg_q ? -quo_q : quo_q;
        remo_d = rneg_q ? -rem_q : rem_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      bmag_q <= '0;
      cnt_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      quot_q <= '0;
      remo_q <= '0;
      dbz_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      bmag_q <= bmag_d;
      cnt_q  <= cnt_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      quot_q <= quot_d;
      remo_q <= remo_d;
      dbz_q  <= dbz_d;
      ovf_q  <= ovf_d;
    end
  end

`ifdef SEQ_DIVIDER_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) trap_q <= 1'b0;
    else     trap_q <= trap_d;
  end
  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized bench for seq_divider; results come from a plain-arithmetic model and are
// compared every cycle out_valid is high, together with handshake latency.
module tb_seq_divider;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] dividend, divisor;
  logic         is_signed;
  logic         out_valid, out_ready;
  logic [W-1:0] quotient, remainder;
  logic         div_by_zero, overflow, trap;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .is_signed(is_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow), .trap(trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    logic         trp;
    int           edges;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t expq[$];
  exp_t fe;
  bit   front_shown = 0;
  bit   idle_chk    = 0;
  int   first_cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    exp_t e;
    longint sa, sb;
    e.dbz = 0; e.ovf = 0; e.trp = 0; e.edges = W + 2;
    if (b == 0) begin
      e.dbz = 1; e.edges = 1;
`ifdef SEQ_DIVIDER_TRAP_EN
      e.trp = 1; e.q = 32'hBBBB_BBBB; e.r = 32'hBBBB_BBBB;
`else
      e.q = 32'hFFFF_FFFF; e.r = a;
`endif
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.ovf = 1; e.edges = 1; e.q = 32'h8000_0000; e.r = 0;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e.q = W'(sa / sb);
      e.r = W'(sa % sb);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Single compare process: tracks accepted operations and checks every valid output cycle.
  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      front_shown = 0;
      idle_chk    = 0;
    end else begin
      if (idle_chk) begin
        chk("in_ready_after_handoff", {31'b0, in_ready}, 32'd1);
        chk("out_valid_after_handoff", {31'b0, out_valid}, 32'd0);
        idle_chk = 0;
      end
      if (out_valid) begin
        if (expq.size() == 0) begin
          chk("spurious_out_valid", {31'b0, out_valid}, 32'd0);
        end else begin
          fe = expq[0];
          if (!front_shown) begin
            chk("latency_cycle", cyc, first_cyc);
            front_shown = 1;
          end
          chk("quotient", quotient, fe.q);
          chk("remainder", remainder, fe.r);
          chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, fe.dbz});
          chk("overflow", {31'b0, overflow}, {31'b0, fe.ovf});
          chk("trap", {31'b0, trap}, {31'b0, fe.trp});
          chk("in_ready_in_done", {31'b0, in_ready}, 32'd0);
          if (out_ready) begin
            void'(expq.pop_front());
            front_shown = 0;
            idle_chk    = 1;
          end
        end
      end else if (front_shown) begin
        chk("result_dropped", {31'b0, out_valid}, 32'd1);
        front_shown = 0;
      end
      if (in_valid && in_ready) begin
        fe = model(dividend, divisor, is_signed);
        first_cyc = cyc + fe.edges;
        expq.push_back(fe);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s, input int delay);
    bit acc = 0;
    int n = 0;
    dividend = a; divisor = b; is_signed = s; in_valid = 1; out_ready = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin acc = 1; break; end
    end
    tick();
    in_valid = 0;
    if (!acc) begin
      chk("accept_timeout", 32'd0, 32'd1);
      return;
    end
    dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom_range(0, 1));
    while (!out_valid && n < 80) begin
      in_valid = 1'($urandom_range(0, 1));
      dividend = $urandom;
      tick();
      n++;
    end
    if (!out_valid) begin
      in_valid = 0;
      chk("result_timeout", 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i < delay; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid  = 0;
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    exp_t pe;
    logic [W-1:0] a, b;
    bit s;
    rst = 1; in_valid = 0; out_ready = 0; dividend = 0; divisor = 0; is_signed = 0;

    // Hand-computed values pin the model itself.
    pe = model(32'd100, 32'd7, 0);
    chk("pin_100_7_q", pe.q, 32'd14);
    chk("pin_100_7_r", pe.r, 32'd2);
    pe = model(32'hFFFF_FFF9, 32'd2, 1);
    chk("pin_m7_2_q", pe.q, 32'hFFFF_FFFD);
    chk("pin_m7_2_r", pe.r, 32'hFFFF_FFFF);
    pe = model(32'hFFFF_FFFF, 32'h8000_0000, 0);
    chk("pin_max_min_q", pe.q, 32'd1);
    chk("pin_max_min_r", pe.r, 32'h7FFF_FFFF);
    pe = model(32'h8000_0000, 32'hFFFF_FFFF, 1);
    chk("pin_ovf_q", pe.q, 32'h8000_0000);
    chk("pin_ovf_flag", {31'b0, pe.ovf}, 32'd1);

    repeat (3) tick();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_flags", {29'b0, div_by_zero, overflow, trap}, 32'd0);
    rst = 0;
    tick();

    run_op(32'd100, 32'd7, 0, 0);
    run_op(32'hFFFF_FFF9, 32'd2, 1, 1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    run_op(32'd1234, 32'd0, 0, 2);
    run_op(32'd1234, 32'd0, 1, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(32'hFFFF_FFFF, 32'h8000_0000, 0, 10);
    run_op(32'h8000_0000, 32'h8000_0000, 1, 0);
    run_op(32'd7, 32'hFFFF_FFF9, 1, 0);

    // Abort mid-CALC, then confirm a clean follow-up operation.
    dividend = 32'd1000; divisor = 32'd3; is_signed = 0; in_valid = 1;
    tick();
    in_valid = 0;
    repeat (10) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (40) tick();
    run_op(32'd50, 32'd5, 0, 0);

    for (int k = 0; k < 200; k++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0: b = 0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 16);
        3: b = 32'h8000_0000;
        4: a = $urandom_range(0, 20);
        5: b = -($urandom_range(1, 16));
        default: ;
      endcase
      run_op(a, b, s, $urandom_range(0, 3));
    end
    repeat (3) tick();
    chk("queue_drained", expq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
